spi_cmd_target: RTL and testbench

SPI responder for the MCU link (`spi1_*`). It deserializes command frames from the MCU's SPI initiator, issues one 17-bit-address bus transaction per frame to the bus arbiter, and returns read data to the MCU. It also paces the MCU through `spi_ready_no`. It sits inside `top`, between the `spi1_*` pins and the arbiter that grants the FPGA the shared CPU/RAM bus.

---
 rtl/spi_cmd_pkg.sv | 29 ++
 rtl/sync2.sv | 23 ++
 rtl/spi_cmd_target.sv | 138 +++++++++++++
 tb/tb_spi_cmd_target.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the MCU SPI command responder.
package spi_cmd_pkg;

  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BIT_CNT_W  = 3;
  localparam int unsigned BYTE_CNT_W = 2;

  localparam int unsigned CMD_RW_BIT  = 7;
  localparam int unsigned CMD_A16_BIT = 0;

  localparam logic [BYTE_CNT_W-1:0] BYTE_CMD     = 2'd0;
  localparam logic [BYTE_CNT_W-1:0] BYTE_ADDR_HI = 2'd1;
  localparam logic [BYTE_CNT_W-1:0] BYTE_ADDR_LO = 2'd2;
  localparam logic [BYTE_CNT_W-1:0] BYTE_WDATA   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    REQ   = 2'd2
  } state_t;

  typedef struct packed {
    logic              rw_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bus_cmd_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with a configurable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_cmd_target.sv
// SPI mode-0 responder: deserializes MCU command frames into one bus
// transaction each and returns read data during byte0 of the next frame.
module spi_cmd_target
  import spi_cmd_pkg::*;
(
  input  logic              clk16_i,
  input  logic              reset_ni,
  input  logic              spi_sck_i,
  input  logic              spi_cs_ni,
  input  logic              spi_sdi_i,
  output logic              spi_sdo_o,
  output logic              spi_sdo_oe,
  output logic              spi_ready_no,
  output logic              bus_req_o,
  input  logic              bus_ack_i,
  output logic              bus_rw_no,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i
);

  logic sck_s, cs_s, sdi_s;
  logic sck_d, cs_d;

  sync2 #(.RST_VAL(1'b1)) u_sync_sck (.clk(clk16_i), .rst_n(reset_ni), .d(spi_sck_i), .q(sck_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_cs  (.clk(clk16_i), .rst_n(reset_ni), .d(spi_cs_ni), .q(cs_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_sdi (.clk(clk16_i), .rst_n(reset_ni), .d(spi_sdi_i), .q(sdi_s));

  state_t                state, state_nxt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [DATA_W-2:0]     rx_sr;
  logic [DATA_W-1:0]     tx_sr;
  logic                  cmd_rw_q;
  logic                  cmd_a16_q;
  logic [DATA_W-1:0]     addr_hi_q;
  logic [DATA_W-1:0]     addr_lo_q;
  logic [DATA_W-1:0]     rd_data;
  bus_cmd_t              bus_q;

  logic                  sck_rise_c;
  logic                  cs_fall_c;
  logic [DATA_W-1:0]     rx_byte_c;
  logic                  byte_done_c;
  logic                  frame_done_c;

  assign sck_rise_c   = sck_s & ~sck_d;
  assign cs_fall_c    = cs_d & ~cs_s;
  assign rx_byte_c    = {rx_sr, sdi_s};
  assign byte_done_c  = (state == SHIFT) && sck_rise_c && (bit_cnt == BIT_CNT_W'(7));
  assign frame_done_c = byte_done_c &&
                        ((byte_cnt == BYTE_WDATA) || ((byte_cnt == BYTE_ADDR_LO) && cmd_rw_q));

  assign spi_sdo_o  = tx_sr[DATA_W-1];
  assign spi_sdo_oe = ~spi_cs_ni;
  assign bus_rw_no  = bus_q.rw_n;
  assign bus_addr_o = bus_q.addr;
  assign bus_data_o = bus_q.data;

  // Next-state logic; a CS fall seen outside IDLE is dropped, not queued.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cs_fall_c) state_nxt = SHIFT;
      SHIFT: begin
        if (frame_done_c)  state_nxt = REQ;
        else if (cs_s)     state_nxt = IDLE;
      end
      REQ:     if (bus_ack_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= IDLE;
      sck_d        <= 1'b1;
      cs_d         <= 1'b1;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      cmd_rw_q     <= 1'b0;
      cmd_a16_q    <= 1'b0;
      addr_hi_q    <= '0;
      addr_lo_q    <= '0;
      rd_data      <= '0;
      bus_q        <= '{rw_n: 1'b1, addr: '0, data: '0};
      bus_req_o    <= 1'b0;
      spi_ready_no <= 1'b0;
    end else begin
      sck_d        <= sck_s;
      cs_d         <= cs_s;
      state        <= state_nxt;
      spi_ready_no <= (state_nxt != IDLE) || !cs_s;

      unique case (state)
        IDLE: begin
          // Keep read data staged so bit7 is on the pin as soon as CS falls.
          tx_sr    <= rd_data;
          bit_cnt  <= '0;
          byte_cnt <= '0;
        end
        SHIFT: begin
          if (sck_rise_c) begin
            rx_sr   <= rx_byte_c[DATA_W-2:0];
            tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == BIT_CNT_W'(7)) begin
              byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
              if (byte_cnt == BYTE_CMD) begin
                cmd_rw_q  <= rx_byte_c[CMD_RW_BIT];
                cmd_a16_q <= rx_byte_c[CMD_A16_BIT];
              end
              if (byte_cnt == BYTE_ADDR_HI) addr_hi_q <= rx_byte_c;
              if (byte_cnt == BYTE_ADDR_LO) addr_lo_q <= rx_byte_c;
            end
          end
          if (frame_done_c) begin
            bus_req_o    <= 1'b1;
            bus_q.rw_n   <= cmd_rw_q;
            bus_q.addr   <= {cmd_a16_q, addr_hi_q,
                             (byte_cnt == BYTE_ADDR_LO) ? rx_byte_c : addr_lo_q};
            bus_q.data   <= (byte_cnt == BYTE_WDATA) ? rx_byte_c : DATA_W'(0);
          end
        end
        REQ: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (bus_q.rw_n) rd_data <= bus_data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_target.sv
// Self-checking bench for spi_cmd_target: frame-level model of the MCU link.
module tb_spi_cmd_target;

  logic        clk16_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        spi_sck_i = 1'b0;
  logic        spi_cs_ni = 1'b1;
  logic        spi_sdi_i = 1'b0;
  logic        spi_sdo_o, spi_sdo_oe, spi_ready_no;
  logic        bus_req_o, bus_rw_no;
  logic        bus_ack_i = 1'b0;
  logic [16:0] bus_addr_o;
  logic [7:0]  bus_data_o;
  logic [7:0]  bus_data_i = 8'h00;

  int n_checks = 0;
  int n_fail = 0;
  int frames_done = 0;
  int oe_bad = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  logic [7:0] model_rd = 8'h00;

  always #5 clk16_i = ~clk16_i;

  spi_cmd_target dut (
    .clk16_i(clk16_i), .reset_ni(reset_ni), .spi_sck_i(spi_sck_i),
    .spi_cs_ni(spi_cs_ni), .spi_sdi_i(spi_sdi_i), .spi_sdo_o(spi_sdo_o),
    .spi_sdo_oe(spi_sdo_oe), .spi_ready_no(spi_ready_no), .bus_req_o(bus_req_o),
    .bus_ack_i(bus_ack_i), .bus_rw_no(bus_rw_no), .bus_addr_o(bus_addr_o),
    .bus_data_o(bus_data_o), .bus_data_i(bus_data_i)
  );

  // Background observers, summarised by test_monitors at the end.
  always @(negedge clk16_i) begin
    if (spi_sdo_oe !== ~spi_cs_ni) oe_bad <= oe_bad + 1;
    if (bus_req_o === 1'b1 && req_prev !== 1'b1) req_rises <= req_rises + 1;
    req_prev <= bus_req_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk16_i);
    #2;
  endtask

  // MCU-side mode-0 transfer at clk16/4; MISO sampled just before each rising edge.
  task automatic spi_xfer(input logic [31:0] mosi, input int nbits, input int extra,
                          output logic [31:0] miso);
    miso = '0;
    wait_clk(4);
    spi_cs_ni = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits + extra; i++) begin
      spi_sdi_i = (i < nbits) ? mosi[31-i] : 1'b0;
      wait_clk(2);
      if (i < nbits) miso[31-i] = spi_sdo_o;
      spi_sck_i = 1'b1;
      wait_clk(2);
      spi_sck_i = 1'b0;
    end
    wait_clk(2);
    spi_cs_ni = 1'b1;
  endtask

  // Arbiter side: wait for a request, hold off `delay` cycles, then ack once.
  task automatic bus_service(input int delay, input logic [7:0] rdata, output bit seen,
                             output bit unstable, output logic rdy_in_ack,
                             output logic rdy_after, output logic req_after);
    int t;
    logic [25:0] snap;
    seen = 1'b0; unstable = 1'b0; rdy_in_ack = 1'bx; rdy_after = 1'bx; req_after = 1'bx;
    t = 0;
    while (bus_req_o !== 1'b1 && t < 300) begin
      @(negedge clk16_i);
      t++;
    end
    if (bus_req_o !== 1'b1) return;
    seen = 1'b1;
    snap = {bus_rw_no, bus_addr_o, bus_data_o};
    repeat (delay) begin
      @(negedge clk16_i);
      if ({bus_rw_no, bus_addr_o, bus_data_o} !== snap || bus_req_o !== 1'b1 ||
          spi_ready_no !== 1'b1) unstable = 1'b1;
    end
    @(posedge clk16_i); #1;
    bus_ack_i = 1'b1; bus_data_i = rdata;
    @(negedge clk16_i);
    if ({bus_rw_no, bus_addr_o, bus_data_o} !== snap || bus_req_o !== 1'b1) unstable = 1'b1;
    rdy_in_ack = spi_ready_no;
    @(posedge clk16_i); #1;
    bus_ack_i = 1'b0; bus_data_i = 8'h00;
    @(negedge clk16_i);
    rdy_after = spi_ready_no;
    req_after = bus_req_o;
  endtask

  task automatic test_reset();
    @(negedge clk16_i);
    n_checks++; if (bus_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus_req_o); end
    n_checks++; if (bus_rw_no !== 1'b1) begin n_fail++; $display("FAIL reset_rw: got %b expected 1", bus_rw_no); end
    n_checks++; if (bus_addr_o !== 17'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus_addr_o); end
    n_checks++; if (bus_data_o !== 8'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus_data_o); end
    n_checks++; if (spi_ready_no !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", spi_ready_no); end
    n_checks++; if (spi_sdo_o !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b expected 0", spi_sdo_o); end
    n_checks++; if (spi_sdo_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sdo_oe: got %b expected 0", spi_sdo_oe); end
  endtask

  task automatic test_write();
    logic [31:0] miso; bit seen, unst; logic ra, rf, qa;
    spi_xfer(32'h01_80_00_5A, 32, 0, miso);
    frames_done++;
    n_checks++; if (miso !== {model_rd, 24'h0}) begin n_fail++; $display("FAIL write_miso: got %h expected %h", miso, {model_rd, 24'h0}); end
    bus_service(5, 8'hEE, seen, unst, ra, rf, qa);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL write_req: got none expected bus_req"); end
    n_checks++; if (unst) begin n_fail++; $display("FAIL write_stable: got unstable expected stable"); end
    n_checks++; if ({bus_rw_no, bus_addr_o, bus_data_o} !== {1'b0, 17'h18000, 8'h5A}) begin n_fail++;
      $display("FAIL write_fields: got rw=%b addr=%h data=%h expected rw=0 addr=18000 data=5a", bus_rw_no, bus_addr_o, bus_data_o); end
    n_checks++; if (ra !== 1'b1) begin n_fail++; $display("FAIL write_ready_ack: got %b expected 1", ra); end
    n_checks++; if (rf !== 1'b0 || qa !== 1'b0) begin n_fail++; $display("FAIL write_after_ack: got ready=%b req=%b expected 0 0", rf, qa); end
  endtask

  task automatic test_read();
    logic [31:0] miso; bit seen, unst; logic ra, rf, qa;
    spi_xfer(32'h80_12_34_00, 24, 0, miso);
    frames_done++;
    bus_service(3, 8'hC3, seen, unst, ra, rf, qa);
    n_checks++; if (!seen || unst) begin n_fail++; $display("FAIL read_req: got seen=%b unstable=%b expected 1 0", seen, unst); end
    n_checks++; if ({bus_rw_no, bus_addr_o} !== {1'b1, 17'h01234}) begin n_fail++;
      $display("FAIL read_fields: got rw=%b addr=%h expected rw=1 addr=01234", bus_rw_no, bus_addr_o); end
    model_rd = 8'hC3;
    spi_xfer(32'h81_FF_FE_00, 24, 0, miso);
    frames_done++;
    n_checks++; if (miso[31:24] !== 8'hC3) begin n_fail++; $display("FAIL readback_byte0: got %h expected c3", miso[31:24]); end
    n_checks++; if (miso[23:8] !== 16'h0) begin n_fail++; $display("FAIL readback_fill: got %h expected 0000", miso[23:8]); end
    bus_service(1, 8'h71, seen, unst, ra, rf, qa);
    n_checks++; if ({bus_rw_no, bus_addr_o} !== {1'b1, 17'h1FFFE}) begin n_fail++;
      $display("FAIL read2_fields: got rw=%b addr=%h expected rw=1 addr=1fffe", bus_rw_no, bus_addr_o); end
    model_rd = 8'h71;
  endtask

  task automatic test_abort();
    logic [31:0] miso; bit seen, unst, any_req; logic ra, rf, qa;
    spi_xfer(32'h01_AB_CD_EF, 12, 0, miso);
    repeat (3) @(posedge clk16_i);
    @(negedge clk16_i);
    n_checks++; if (spi_ready_no !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b expected 0", spi_ready_no); end
    any_req = 1'b0;
    repeat (30) begin @(negedge clk16_i); if (bus_req_o !== 1'b0) any_req = 1'b1; end
    n_checks++; if (any_req) begin n_fail++; $display("FAIL abort_no_req: got req expected none"); end
    spi_xfer(32'h00_42_17_99, 32, 0, miso);
    frames_done++;
    n_checks++; if (miso[31:24] !== model_rd) begin n_fail++; $display("FAIL abort_next_miso: got %h expected %h", miso[31:24], model_rd); end
    bus_service(2, 8'h00, seen, unst, ra, rf, qa);
    n_checks++; if (!seen || {bus_rw_no, bus_addr_o, bus_data_o} !== {1'b0, 17'h04217, 8'h99}) begin n_fail++;
      $display("FAIL abort_next_fields: got seen=%b rw=%b addr=%h data=%h expected 1 0 04217 99", seen, bus_rw_no, bus_addr_o, bus_data_o); end
  endtask

  task automatic test_reset_in_req();
    logic [31:0] miso; bit seen, unst; logic ra, rf, qa; int t;
    spi_xfer(32'h80_00_10_00, 24, 0, miso);
    frames_done++;
    bus_service(0, 8'h96, seen, unst, ra, rf, qa);
    model_rd = 8'h96;
    spi_xfer(32'h01_55_AA_3C, 32, 0, miso);
    frames_done++;
    t = 0;
    while (bus_req_o !== 1'b1 && t < 100) begin @(negedge clk16_i); t++; end
    n_checks++; if (bus_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_req_pre: got %b expected 1", bus_req_o); end
    @(posedge clk16_i); #3;
    reset_ni = 1'b0;
    #1;
    n_checks++; if (bus_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_async: got %b expected 0", bus_req_o); end
    n_checks++; if ({bus_rw_no, bus_addr_o, bus_data_o, spi_ready_no, spi_sdo_o} !== {1'b1, 17'h0, 8'h0, 1'b0, 1'b0}) begin n_fail++;
      $display("FAIL rst_outputs: got rw=%b addr=%h data=%h ready=%b sdo=%b expected 1 0 0 0 0",
               bus_rw_no, bus_addr_o, bus_data_o, spi_ready_no, spi_sdo_o); end
    @(posedge clk16_i); #2;
    reset_ni = 1'b1;
    model_rd = 8'h00;
    spi_xfer(32'h80_00_20_00, 24, 0, miso);
    frames_done++;
    n_checks++; if (miso[31:24] !== model_rd) begin n_fail++; $display("FAIL rst_readback: got %h expected %h", miso[31:24], model_rd); end
    bus_service(1, 8'h3C, seen, unst, ra, rf, qa);
    model_rd = 8'h3C;
  endtask

  task automatic test_slow_ack();
    logic [31:0] miso; bit seen, unst; logic ra, rf, qa;
    spi_xfer(32'h00_BE_EF_A5, 32, 0, miso);
    frames_done++;
    bus_service(200, 8'h00, seen, unst, ra, rf, qa);
    n_checks++; if (!seen || unst) begin n_fail++; $display("FAIL slow_stable: got seen=%b unstable=%b expected 1 0", seen, unst); end
    n_checks++; if (ra !== 1'b1 || rf !== 1'b0) begin n_fail++; $display("FAIL slow_ready: got ack=%b after=%b expected 1 0", ra, rf); end
    n_checks++; if ({bus_rw_no, bus_addr_o, bus_data_o} !== {1'b0, 17'h0BEEF, 8'hA5}) begin n_fail++;
      $display("FAIL slow_fields: got rw=%b addr=%h data=%h expected 0 0beef a5", bus_rw_no, bus_addr_o, bus_data_o); end
  endtask

  task automatic test_random();
    logic [31:0] miso, mosi; bit seen, unst; logic ra, rf, qa;
    logic rw; logic [16:0] addr; logic [7:0] data, rdat, cmd; int nb, extra;
    for (int n = 0; n < 16; n++) begin
      rw    = 1'($urandom_range(0, 1));
      addr  = 17'($urandom);
      data  = 8'($urandom);
      rdat  = 8'($urandom);
      cmd   = {rw, 6'($urandom), addr[16]};
      mosi  = {cmd, addr[15:0], rw ? 8'h00 : data};
      nb    = rw ? 24 : 32;
      extra = ($urandom_range(0, 3) == 0) ? 8 : 0;
      spi_xfer(mosi, nb, extra, miso);
      frames_done++;
      n_checks++; if (miso[31:24] !== model_rd) begin n_fail++; $display("FAIL rand%0d_byte0: got %h expected %h", n, miso[31:24], model_rd); end
      n_checks++; if (miso[23:0] !== 24'h0) begin n_fail++; $display("FAIL rand%0d_fill: got %h expected 000000", n, miso[23:0]); end
      bus_service(int'($urandom_range(0, 6)), rdat, seen, unst, ra, rf, qa);
      n_checks++; if (!seen || unst) begin n_fail++; $display("FAIL rand%0d_req: got seen=%b unstable=%b expected 1 0", n, seen, unst); end
      n_checks++; if (bus_rw_no !== rw || bus_addr_o !== addr) begin n_fail++;
        $display("FAIL rand%0d_fields: got rw=%b addr=%h expected rw=%b addr=%h", n, bus_rw_no, bus_addr_o, rw, addr); end
      if (!rw) begin
        n_checks++; if (bus_data_o !== data) begin n_fail++; $display("FAIL rand%0d_wdata: got %h expected %h", n, bus_data_o, data); end
      end else begin
        model_rd = rdat;
      end
    end
  endtask

  task automatic test_monitors();
    @(negedge clk16_i);
    n_checks++; if (oe_bad != 0) begin n_fail++; $display("FAIL sdo_oe_track: got %0d mismatching cycles expected 0", oe_bad); end
    n_checks++; if (req_rises != frames_done) begin n_fail++; $display("FAIL req_count: got %0d rises expected %0d", req_rises, frames_done); end
  endtask

  initial begin
    wait_clk(4);
    test_reset();
    reset_ni = 1'b1;
    wait_clk(4);
    test_write();
    test_read();
    test_abort();
    test_reset_in_req();
    test_slow_ack();
    test_random();
    wait_clk(10);
    test_monitors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
